// File: rtl/ps2_dev_tx.sv
// Device-side PS/2 transmitter (keyboard emulator).
// Serialises one byte per frame (start, 8 data LSB first, odd parity, stop)
// and generates the PS/2 clock itself. If the host pulls the clock low while
// the device is releasing it, the frame is aborted and retried from the start.
module ps2_dev_tx #(
    parameter int clk_freq = 50000000,
    parameter int ps2_freq = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    input  logic       ps2_clk_in
);

    localparam int HALF = clk_freq / (2 * ps2_freq);
    localparam int CW   = $clog2(2 * HALF);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(2 * HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        HIGH,
        LOW,
        GAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          clk_out_q, clk_out_d;
    logic          dat_out_q, dat_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          clkSync1_q, clkSync2_q;
    logic          clkDly1_q, clkDly2_q;

    logic [10:0]   frame;
    logic [3:0]    nextBit;
    logic          inhibit;

    assign frame   = {1'b1, ~^data_q, data_q, 1'b0};
    assign nextBit = bit_q + 4'd1;

    // The synchronised clock reflects the line two cycles ago, so it is
    // compared against our own drive delayed by the same two cycles; this
    // keeps our own low phase from being mistaken for a host inhibit.
    assign inhibit = ~clkSync2_q & clk_out_q & clkDly2_q;

    // Two-flop synchroniser for the sensed clock plus matching drive delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkSync1_q <= 1'b0;
            clkSync2_q <= 1'b0;
            clkDly1_q  <= 1'b1;
            clkDly2_q  <= 1'b1;
        end else begin
            clkSync1_q <= ps2_clk_in;
            clkSync2_q <= clkSync1_q;
            clkDly1_q  <= clk_out_q;
            clkDly2_q  <= clkDly1_q;
        end
    end

    // State, divider, shift data and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            clk_out_q <= 1'b1;
            dat_out_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            clk_out_q <= clk_out_d;
            dat_out_q <= dat_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic; the divider reloads to zero on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        data_d    = data_q;
        clk_out_d = clk_out_q;
        dat_out_d = dat_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b1;
                dat_out_d = 1'b1;
                if (tx_wr && !busy_q) begin
                    data_d  = tx_data;
                    busy_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                clk_out_d = 1'b1;
                dat_out_d = 1'b1;
                if (!clkSync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    dat_out_d = frame[0];
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (inhibit && bit_q <= 4'd9) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                    dat_out_d = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = HOLD;
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                    if (bit_q == 4'd10) begin
                        dat_out_d = 1'b1;
                        state_d   = GAP;
                    end else begin
                        bit_d     = nextBit;
                        dat_out_d = frame[nextBit];
                        state_d   = HIGH;
                    end
                end
            end
            GAP: begin
                clk_out_d = 1'b1;
                dat_out_d = 1'b1;
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_abort    = abort_q;
    assign ps2_clk_out = clk_out_q;
    assign ps2_dat_out = dat_out_q;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Self-checking bench for ps2_dev_tx with HALF = 4.
// Expected timing is derived from frame-level rules (start cycle, 2*HALF per
// bit, sync latency of two cycles) and the sampled bits are decoded by a
// simple host-side receiver.
module tb_ps2_dev_tx;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       hostClk;
    wire        tx_busy, tx_done, tx_abort, ps2_clk_out, ps2_dat_out;
    wire        ps2_clk_in;

    int         checks = 0;
    int         errors = 0;
    int         rel = 0;
    int         fallRel[$];
    bit         fallBit[$];
    logic [10:0] lastBits;
    int         lastDone;

    // The sensed clock line is the wired-AND of device and host drives.
    assign ps2_clk_in = ps2_clk_out & hostClk;

    ps2_dev_tx #(.clk_freq(800), .ps2_freq(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .ps2_clk_out(ps2_clk_out),
        .ps2_dat_out(ps2_dat_out),
        .ps2_clk_in (ps2_clk_in)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    // Sends one byte and checks it cycle by cycle. inhBit >= 0 makes the host
    // pull the clock low at offset inhOff into that bit's high phase for
    // inhLen cycles; relRelease >= 0 holds the host clock low before the
    // write until that relative cycle; extraWr injects an ignored write.
    task automatic applyStimulus(input logic [7:0] data, input int inhBit, input int inhOff,
                                 input int inhLen, input int relRelease, input int extraWr);
        int          s1, s, l, abortRel, d;
        int          expRel[$];
        bit          expBit[$];
        logic [10:0] fr;
        bit          prevClk, doneSeen, hb;
        logic [7:0]  rxByte;
        fr = {1'b1, ~^data, data, 1'b0};
        if (relRelease >= 0) begin
            hostClk = 1'b0;
            repeat (3) tick();
        end
        s1 = 1 + 2 * H;
        if (relRelease >= 0) s1 = relRelease + 2 + 2 * H;
        abortRel = -1;
        l = -100;
        s = s1;
        if (inhBit >= 0) begin
            l = s1 + 2 * H * inhBit + inhOff;
            abortRel = l + 3;
            s = l + inhLen + 2 + 2 * H;
            for (int k = 0; k < inhBit; k++) begin
                expRel.push_back(s1 + H + 2 * H * k);
                expBit.push_back(fr[k]);
            end
        end
        for (int k = 0; k < 11; k++) begin
            expRel.push_back(s + H + 2 * H * k);
            expBit.push_back(fr[k]);
        end
        d = s + 24 * H;
        fallRel.delete();
        fallBit.delete();
        rel = 0;
        tx_data = data;
        tx_wr = 1'b1;
        prevClk = ps2_clk_out;
        doneSeen = 1'b0;
        while (!doneSeen && rel < d + 20) begin
            tick();
            tx_wr = 1'b0;
            tx_data = 8'($urandom);
            checkOutput("tx_busy", 32'(tx_busy), 32'(rel < d));
            checkOutput("tx_done", 32'(tx_done), 32'(rel == d));
            checkOutput("tx_abort", 32'(tx_abort), 32'(rel == abortRel));
            if (rel == abortRel) begin
                checkOutput("abort_clk_released", 32'(ps2_clk_out), 32'd1);
                checkOutput("abort_dat_released", 32'(ps2_dat_out), 32'd1);
            end
            if (prevClk && !ps2_clk_out) begin
                fallRel.push_back(rel);
                fallBit.push_back(ps2_dat_out);
            end
            prevClk = ps2_clk_out;
            if (tx_done === 1'b1) doneSeen = 1'b1;
            hb = 1'b1;
            if (relRelease >= 0 && rel < relRelease) hb = 1'b0;
            if (inhBit >= 0 && rel >= l && rel < l + inhLen) hb = 1'b0;
            hostClk = hb;
            if (rel == extraWr) begin
                tx_wr = 1'b1;
                tx_data = 8'h55;
            end
        end
        hostClk = 1'b1;
        checkOutput("done_seen", 32'(doneSeen), 32'd1);
        lastDone = rel;
        checkOutput("fall_count", 32'(fallRel.size()), 32'(expRel.size()));
        for (int i = 0; i < fallRel.size() && i < expRel.size(); i++) begin
            checkOutput("fall_cycle", 32'(fallRel[i]), 32'(expRel[i]));
            checkOutput("fall_bit", 32'(fallBit[i]), 32'(expBit[i]));
        end
        lastBits = 'x;
        if (fallBit.size() >= 11) begin
            for (int i = 0; i < 11; i++) lastBits[i] = fallBit[fallBit.size() - 11 + i];
            rxByte = lastBits[8:1];
            checkOutput("rx_start", 32'(lastBits[0]), 32'd0);
            checkOutput("rx_stop", 32'(lastBits[10]), 32'd1);
            checkOutput("rx_parity_odd", 32'(^lastBits[9:1]), 32'd1);
            checkOutput("rx_byte", 32'(rxByte), 32'(data));
        end
    endtask

    // Directed and randomized sequence.
    initial begin
        int bitSel, offSel, lenSel, relSel, wrSel;
        rst = 1'b1;
        tx_wr = 1'b0;
        tx_data = 8'h00;
        hostClk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_clk", 32'(ps2_clk_out), 32'd1);
        checkOutput("reset_dat", 32'(ps2_dat_out), 32'd1);
        checkOutput("reset_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset_done", 32'(tx_done), 32'd0);
        checkOutput("reset_abort", 32'(tx_abort), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] basic 0x1C frame with ignored 0x55 write");
        applyStimulus(8'h1C, -1, 0, 0, -1, 30);
        checkOutput("bits_1C", 32'(lastBits), 32'(11'b10000111000));
        checkOutput("done_cycle_1C", 32'(lastDone), 32'd105);

        $display("[TB] parity frames back to back");
        applyStimulus(8'h00, -1, 0, 0, -1, -1);
        applyStimulus(8'hFF, -1, 0, 0, -1, -1);
        applyStimulus(8'h01, -1, 0, 0, -1, -1);

        $display("[TB] host inhibit at bit 4");
        repeat (5) tick();
        applyStimulus(8'h1C, 4, 1, 10, -1, -1);

        $display("[TB] host holds clock low across the write");
        repeat (5) tick();
        applyStimulus(8'h1C, -1, 0, 0, 7, -1);

        $display("[TB] randomized frames");
        for (int n = 0; n < 8; n++) begin
            bitSel = -1;
            relSel = -1;
            wrSel  = -1;
            offSel = int'($urandom_range(0, H - 3));
            lenSel = int'($urandom_range(3, 20));
            case ($urandom_range(0, 2))
                0: bitSel = int'($urandom_range(0, 9));
                1: relSel = int'($urandom_range(1, 15));
                default: wrSel = int'($urandom_range(2, 60));
            endcase
            if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 6))) tick();
            applyStimulus(8'($urandom), bitSel, offSel, lenSel, relSel, wrSel);
        end

        $display("[TB] reset in the middle of bit 6");
        repeat (4) tick();
        rel = 0;
        tx_data = 8'h1C;
        tx_wr = 1'b1;
        tick();
        tx_wr = 1'b0;
        while (rel < 58) tick();
        checkOutput("bit6_dat_low", 32'(ps2_dat_out), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_clk", 32'(ps2_clk_out), 32'd1);
        checkOutput("midrst_dat", 32'(ps2_dat_out), 32'd1);
        checkOutput("midrst_busy", 32'(tx_busy), 32'd0);
        repeat (2) begin
            tick();
            checkOutput("midrst_done", 32'(tx_done), 32'd0);
            checkOutput("midrst_abort", 32'(tx_abort), 32'd0);
        end
        rst = 1'b0;
        repeat (2) tick();
        applyStimulus(8'hF0, -1, 0, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
